// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline stage buffer (main + skid) with registered ready/valid,
// flush support, optional bubble zeroing and a saturating backpressure counter.
module pipe_stage_buf #(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int EXC_W       = 32,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_inst,
    input  logic [EXC_W-1:0]  in_except,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic [EXC_W-1:0]  out_except,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bp_cycles
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] inst;
        logic [EXC_W-1:0]  exc;
    } entry_t;

    localparam logic [CNT_W-1:0] BP_MAX = {CNT_W{1'b1}};

    entry_t           main_q, skid_q, main_nxt, skid_nxt, in_ent;
    logic [1:0]       occ_q, occ_nxt;
    logic             in_ready_q, out_valid_q;
    logic [CNT_W-1:0] bp_q;
    logic             accept, pop;

    assign in_ent = '{pc: in_pc, inst: in_inst, exc: in_except};
    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // Next occupancy and entry contents; main always holds the FIFO head.
    always_comb begin
        occ_nxt  = occ_q;
        main_nxt = main_q;
        skid_nxt = skid_q;
        if (flush) begin
            occ_nxt = 2'd0;
            if (ZERO_BUBBLE != 0) main_nxt = '0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (accept) begin
                        main_nxt = in_ent;
                        occ_nxt  = 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && pop) begin
                        main_nxt = in_ent;
                    end else if (accept) begin
                        skid_nxt = in_ent;
                        occ_nxt  = 2'd2;
                    end else if (pop) begin
                        occ_nxt = 2'd0;
                        if (ZERO_BUBBLE != 0) main_nxt = '0;
                    end
                end
                2'd2: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        main_nxt = skid_q;
                        occ_nxt  = 2'd1;
                    end
                end
                default: occ_nxt = 2'd0;
            endcase
        end
    end

    // Storage and handshake registers; ready/valid derive from next occupancy
    // so neither has a combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            occ_q       <= 2'd0;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            occ_q       <= occ_nxt;
            main_q      <= main_nxt;
            skid_q      <= skid_nxt;
            in_ready_q  <= (occ_nxt != 2'd2);
            out_valid_q <= (occ_nxt != 2'd0);
        end
    end

    // Saturating count of stalled cycles; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bp_q <= '0;
        end else if (out_valid_q && !out_ready && bp_q != BP_MAX) begin
            bp_q <= bp_q + 1'b1;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_pc     = main_q.pc;
    assign out_inst   = main_q.inst;
    assign out_except = main_q.exc;
    assign occupancy  = occ_q;
    assign bp_cycles  = bp_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: table-driven vectors plus hand-written corner
// sequences, with a queue scoreboard tracking expected FIFO contents.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_inst, in_except;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_pc, a_out_inst, a_out_except;
    logic [1:0]  a_occ;
    logic [15:0] a_bp;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_pc, b_out_inst, b_out_except;
    logic [1:0]  b_occ;
    logic [2:0]  b_bp;

    always #5 clk = ~clk;

    pipe_stage_buf u_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_except(in_except),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_inst(a_out_inst), .out_except(a_out_except),
        .occupancy(a_occ), .bp_cycles(a_bp)
    );

    pipe_stage_buf #(.ZERO_BUBBLE(0), .CNT_W(3)) u_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_except(in_except),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_inst(b_out_inst), .out_except(b_out_except),
        .occupancy(b_occ), .bp_cycles(b_bp)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exc;
    } ent_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_occ;
        logic [31:0] exp_opc;
        logic [15:0] exp_bp;
    } vec_t;

    ent_t q[$];
    int   bpa = 0;
    int   bpb = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[11];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    function automatic logic [31:0] exc_of(input logic [31:0] pc);
        return pc + 32'h0000_1000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive this cycle's inputs, then wait to mid-cycle for sampling.
    task automatic set_in(input logic v, input logic [31:0] pc, input logic ordy,
                          input logic fl, input logic rst);
        reset     = rst;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst_of(pc);
        in_except = exc_of(pc);
        out_ready = ordy;
        flush     = fl;
        #4;
    endtask

    // Compare both DUTs against the scoreboard, update it, and cross the edge.
    task automatic finish_cycle();
        int  n;
        bit  stall;
        ent_t e;
        n = q.size();
        chk("occ_a", 64'(a_occ), 64'(n));
        chk("occ_b", 64'(b_occ), 64'(n));
        chk("in_ready", 64'(a_in_ready), 64'(n < 2));
        chk("out_valid", 64'(a_out_valid), 64'(n > 0));
        chk("bp_a", 64'(a_bp), 64'(bpa));
        chk("bp_b", 64'(b_bp), 64'(bpb));
        if (n > 0) begin
            chk("head_pc", 64'(a_out_pc), 64'(q[0].pc));
            chk("head_inst", 64'(a_out_inst), 64'(q[0].inst));
            chk("head_exc", 64'(a_out_except), 64'(q[0].exc));
            chk("head_pc_b", 64'(b_out_pc), 64'(q[0].pc));
        end else begin
            chk("bubble_pc", 64'(a_out_pc), 64'd0);
            chk("bubble_inst", 64'(a_out_inst), 64'd0);
            chk("bubble_exc", 64'(a_out_except), 64'd0);
        end
        stall = (n > 0) && !out_ready;
        if (!reset) begin
            q.delete();
            bpa = 0;
            bpb = 0;
        end else begin
            if (stall && bpa < 65535) bpa++;
            if (stall && bpb < 7) bpb++;
            if (flush) begin
                q.delete();
            end else begin
                if (n > 0 && out_ready) void'(q.pop_front());
                if (in_valid && n < 2) begin
                    e.pc = in_pc; e.inst = in_inst; e.exc = in_except;
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [31:0] pc, input logic ordy,
                       input logic fl, input logic rst);
        set_in(v, pc, ordy, fl, rst);
        finish_cycle();
    endtask

    initial begin
        // streaming then backpressure; row inputs and outputs seen that cycle
        tbl[0]  = '{1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0,   16'd0};
        tbl[1]  = '{1'b1, 32'h104, 1'b1, 1'b1, 1'b1, 2'd1, 32'h100, 16'd0};
        tbl[2]  = '{1'b1, 32'h108, 1'b1, 1'b1, 1'b1, 2'd1, 32'h104, 16'd0};
        tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 2'd1, 32'h108, 16'd0};
        tbl[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 2'd0, 32'h0,   16'd0};
        tbl[5]  = '{1'b1, 32'hA,   1'b0, 1'b1, 1'b0, 2'd0, 32'h0,   16'd0};
        tbl[6]  = '{1'b1, 32'hB,   1'b0, 1'b1, 1'b1, 2'd1, 32'hA,   16'd0};
        tbl[7]  = '{1'b1, 32'hC,   1'b0, 1'b0, 1'b1, 2'd2, 32'hA,   16'd1};
        tbl[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 2'd2, 32'hA,   16'd2};
        tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 2'd1, 32'hB,   16'd2};
        tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 2'd0, 32'h0,   16'd2};

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0; in_except = '0;
        repeat (2) @(posedge clk);
        #1;
        #4;
        chk("rst_occ", 64'(a_occ), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_pc", 64'(a_out_pc), 64'd0);
        chk("rst_bp", 64'(a_bp), 64'd0);
        @(posedge clk);
        #1;

        // first row accepts in the first cycle with reset released
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].v, tbl[i].pc, tbl[i].ordy, 1'b0, 1'b1);
            chk($sformatf("tbl%0d_rdy", i), 64'(a_in_ready), 64'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_ov", i), 64'(a_out_valid), 64'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d_occ", i), 64'(a_occ), 64'(tbl[i].exp_occ));
            chk($sformatf("tbl%0d_opc", i), 64'(a_out_pc), 64'(tbl[i].exp_opc));
            chk($sformatf("tbl%0d_bp", i), 64'(a_bp), 64'(tbl[i].exp_bp));
            finish_cycle();
        end

        // flush while full with a same-cycle push
        cyc(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h304, 1'b0, 1'b0, 1'b1);
        set_in(1'b1, 32'h308, 1'b0, 1'b1, 1'b1);
        chk("pre_flush_occ", 64'(a_occ), 64'd2);
        finish_cycle();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("flush_occ", 64'(a_occ), 64'd0);
        chk("flush_ov", 64'(a_out_valid), 64'd0);
        chk("flush_rdy", 64'(a_in_ready), 64'd1);
        chk("flush_exc", 64'(a_out_except), 64'd0);
        chk("flush_bp_kept", 64'(a_bp), 64'd4);
        finish_cycle();

        // reset mid-stream with occupancy 2 and bp_cycles 5
        cyc(1'b1, 32'h400, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h404, 1'b0, 1'b0, 1'b1);
        set_in(1'b1, 32'h408, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_occ", 64'(a_occ), 64'd2);
        chk("pre_rst_bp", 64'(a_bp), 64'd5);
        finish_cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("mrst_occ", 64'(a_occ), 64'd0);
        chk("mrst_ov", 64'(a_out_valid), 64'd0);
        chk("mrst_rdy", 64'(a_in_ready), 64'd1);
        chk("mrst_pc", 64'(a_out_pc), 64'd0);
        chk("mrst_inst", 64'(a_out_inst), 64'd0);
        chk("mrst_bp", 64'(a_bp), 64'd0);
        chk("mrst_b_pc", 64'(b_out_pc), 64'd0);
        finish_cycle();

        // saturation of the 3-bit counter
        cyc(1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("sat_b", 64'(b_bp), 64'd7);
        chk("sat_a", 64'(a_bp), 64'd10);
        finish_cycle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("sat_b_hold", 64'(b_bp), 64'd7);
        finish_cycle();
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // hold-last-content variant after final pop
        cyc(1'b1, 32'h200, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("hold_b_ov", 64'(b_out_valid), 64'd0);
        chk("hold_b_pc", 64'(b_out_pc), 64'h200);
        chk("hold_b_inst", 64'(b_out_inst), 64'(inst_of(32'h200)));
        chk("hold_a_pc", 64'(a_out_pc), 64'd0);
        finish_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter PC_W, default 32, width of the pc field.
REQ-002 Parameter DATA_W, default 32, width of the inst/payload field.
REQ-003 Parameter EXC_W, default 32, width of the exception field.
REQ-004 Parameter ZERO_BUBBLE, default 1; 1 = out_pc/out_inst/out_except driven to zero whenever out_valid=0, 0 = hold last content.
REQ-005 Parameter CNT_W, default 16, width of the backpressure counter.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-008 flush  input  1  discard all buffered entries (branch/exception redirect).
REQ-009 in_valid  input  1  upstream has a valid entry.
REQ-010 in_ready  output  1  buffer can accept an entry this cycle.
REQ-011 in_pc / in_inst / in_except  input  PC_W / DATA_W / EXC_W  upstream payload.
REQ-012 out_valid  output  1  out_* payload is valid.
REQ-013 out_ready  input  1  downstream consumes the entry this cycle.
REQ-014 out_pc / out_inst / out_except  output  PC_W / DATA_W / EXC_W  head entry payload.
REQ-015 occupancy  output  2  entries held (0..2).
REQ-016 bp_cycles  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Storage SHALL be two entries: main (drives out_*) and skid; FIFO order SHALL be preserved.
REQ-018 Accept SHALL occur when in_valid=1 and in_ready=1; pop SHALL occur when out_valid=1 and out_ready=1.
REQ-019 in_ready SHALL be a registered signal equal to (occupancy<2), with no combinational path from out_ready.
REQ-020 out_valid SHALL equal (occupancy>=1); out_* SHALL be registered outputs.
REQ-021 Latency: an entry accepted in cycle N SHALL appear on out_* with out_valid=1 in cycle N+1 when occupancy was 0 or a pop occurred in cycle N with occupancy 1.
REQ-022 occupancy 0, accept: main <= input, occupancy -> 1.
REQ-023 occupancy 1, accept and no pop: skid <= input, occupancy -> 2.
REQ-024 occupancy 1, accept and pop: main <= input, occupancy stays 1.
REQ-025 occupancy 1, pop and no accept: occupancy -> 0.
REQ-026 occupancy 2, pop: main <= skid, occupancy -> 1; no accept possible (in_ready=0).
REQ-027 Sustained in_valid=1 and out_ready=1 SHALL give one entry per cycle throughput.
REQ-028 flush=1 SHALL set occupancy to 0 next cycle, ignore any same-cycle accept or pop, and set in_ready=1 next cycle.
REQ-029 flush SHALL take priority over accept/pop; reset SHALL take priority over flush.
REQ-030 With ZERO_BUBBLE=1, out_* SHALL be all zeros in every cycle where out_valid=0, including after flush and after the last pop.
REQ-031 bp_cycles SHALL increment by 1 per backpressure cycle and saturate at 2^CNT_W-1 without wrap-around; it SHALL NOT be cleared by flush.

Reset
REQ-032 While reset=0 at a clk edge: occupancy=0, out_valid=0, in_ready=1, out_pc/out_inst/out_except=0, bp_cycles=0, skid contents=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries regardless of flush, in_valid or out_ready.
REQ-034 After reset is released, the first accept SHALL be possible in the first cycle with reset=1.

Verification
REQ-035 Streaming: out_ready=1, in_pc=0x100,0x104,0x108 on consecutive cycles -> out_pc 0x100,0x104,0x108 one cycle later each, occupancy=1, in_ready stays 1.
REQ-036 Backpressure: out_ready=0, push 0xA,0xB,0xC -> 0xA,0xB held, occupancy=2, in_ready=0, 0xC not accepted; out_ready=1 for 2 cycles -> out_inst 0xA then 0xB, bp_cycles equals stalled-cycle count.
REQ-037 Flush with occupancy 2 and in_valid=1 in the same cycle -> next cycle occupancy=0, out_valid=0, out_pc/inst/except=0, in_ready=1, flushed-cycle input absent.
REQ-038 Reset mid-stream (reset=0 one cycle, occupancy 2, bp_cycles=5) -> next cycle every output at REQ-032 values.
REQ-039 Saturation with CNT_W=3: 10 consecutive backpressure cycles -> bp_cycles=7 and holds at 7.
REQ-040 ZERO_BUBBLE=0: after the last pop of in_pc=0x200 -> out_valid=0, out_pc holds 0x200.
